if_fetch: RTL

Instruction-fetch stage for the 5-stage RISC-V core: owns the PC, fetches each 32-bit instruction as four byte reads over an 8-bit memory port, and drives the IF/ID pipeline register. Obeys the 6-bit stall vector from the pipeline controller. While a fetch is in flight it raises its own stall request `req_if`, which the controller answers with `6'b000011`. Accepts branch redirects from EX.

---
 rtl/if_fetch_pkg.sv | 30 +++
 rtl/if_fetch_id_reg.sv | 52 +++++
 rtl/if_fetch.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage:
//                stall-vector width, reset/stop levels, NOP encoding, fetch
//                FSM state encodings and a byte-lane helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

    localparam int          c_ctrl_width  = 6;              // stall vector width (5:0)
    localparam int          c_inst_addr_w = 32;             // instruction address bus
    localparam logic        c_rst_enable  = 1'b1;           // reset asserted level
    localparam logic        c_stop        = 1'b1;           // stall bit "stop" level
    localparam logic [31:0] c_nop_inst    = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_READY = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    // Lowest bit position of byte lane idx inside a little-endian 32-bit word.
    function automatic logic [4:0] byte_lsb(input logic [1:0] idx);
        return {idx, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : Stage latch carrying a PC/instruction pair to the next stage.
//                Applies the controller stall rule: pass when this stage runs,
//                hold when this and the next stage stop, insert a bubble when
//                only this stage stops. A flush forces a bubble and keeps PC.
//                Reusable for other stage latches via the width parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = c_inst_addr_w,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = c_nop_inst
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall_cur,   // stall bit of the producing stage
    input  logic              i_stall_next,  // stall bit of the consuming stage
    input  logic              i_flush,       // redirect/halt: force a bubble
    input  logic              i_valid,       // i_inst is a real instruction
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_inst,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_inst
);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_inst;

    // Latch update: flush beats the stall rule; a non-valid input becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_pc   <= '0;
            r_inst <= NOP_INST;
        end else if (i_flush) begin
            r_inst <= NOP_INST;
        end else if (i_stall_cur != c_stop) begin
            r_pc   <= i_pc;
            r_inst <= i_valid ? i_inst : NOP_INST;
        end else if (i_stall_next != c_stop) begin
            r_inst <= NOP_INST;
        end
    end

    assign o_pc   = r_pc;
    assign o_inst = r_inst;

endmodule
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Instruction-fetch stage. Owns the PC, assembles each 32-bit
//                instruction from four little-endian byte reads over an 8-bit
//                memory port, requests a pipeline stall while a fetch is in
//                flight and feeds the IF/ID latch. Branch redirects from EX
//                take priority over stall and memory responses.
//  Config      : IF_ALIGN_CHECK_EN - when defined, a branch to a target with
//                addr[1:0] != 0 sets the sticky if_misalign flag and parks the
//                stage in S_HALT until reset. When undefined, the target is
//                force-aligned and if_misalign is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = c_nop_inst
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [c_ctrl_width-1:0] stall,
    input  logic                    branch_en,
    input  logic [31:0]             branch_addr,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_ready,
    input  logic [7:0]              mem_rdata,
    output logic                    req_if,
    output logic [31:0]             id_pc,
    output logic [31:0]             id_inst,
    output logic                    if_misalign
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [1:0]   r_cnt;
    logic [1:0]   w_cnt_nxt;
    logic [31:0]  r_buf;
    logic [31:0]  w_buf_nxt;
    logic         w_flush;
    logic         w_valid;
    logic         w_misalign_nxt;
    logic         r_misalign;

    // Next-state logic: a redirect wins over everything, otherwise walk the FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_cnt_nxt      = r_cnt;
        w_buf_nxt      = r_buf;
        w_flush        = 1'b0;
        w_valid        = 1'b0;
        w_misalign_nxt = r_misalign;

        if (branch_en && (r_state != S_HALT)) begin
            // Any byte returned this cycle and any partial word are dropped.
            w_flush   = 1'b1;
            w_cnt_nxt = 2'd0;
`ifdef IF_ALIGN_CHECK_EN
            w_pc_nxt  = branch_addr;
            if (branch_addr[1:0] != 2'b00) begin
                w_state_nxt    = S_HALT;
                w_misalign_nxt = 1'b1;
            end else begin
                w_state_nxt    = S_FETCH;
            end
`else
            w_pc_nxt    = {branch_addr[31:2], 2'b00};
            w_state_nxt = S_FETCH;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_FETCH;
                    w_cnt_nxt   = 2'd0;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        w_buf_nxt[byte_lsb(r_cnt) +: 8] = mem_rdata;
                        w_cnt_nxt                       = r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            w_state_nxt = S_READY;
                        end
                    end
                end
                S_READY: begin
                    // The assembled word is offered; it is consumed only when IF runs.
                    w_valid = 1'b1;
                    if (stall[1] != c_stop) begin
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = S_FETCH;
                    end
                end
                S_HALT: begin
                    w_flush = 1'b1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_cnt   <= 2'd0;
            r_buf   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

`ifdef IF_ALIGN_CHECK_EN
    // Sticky misaligned-target flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst == c_rst_enable) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end

    logic w_unused_stall;
    assign w_unused_stall = ^{stall[c_ctrl_width-1:3], stall[0]};
`else
    assign r_misalign = 1'b0;

    logic w_unused_bits;
    assign w_unused_bits = ^{stall[c_ctrl_width-1:3], stall[0], branch_addr[1:0], w_misalign_nxt};
`endif

    assign if_misalign = r_misalign;

    // Memory request is gated by reset so nothing is requested while it is held.
    assign mem_req  = (r_state == S_FETCH) && (rst != c_rst_enable);
    assign req_if   = mem_req;
    assign mem_addr = (rst == c_rst_enable) ? RESET_PC : (r_pc + {30'd0, r_cnt});

    if_id_reg #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .i_stall_cur  (stall[1]),
        .i_stall_next (stall[2]),
        .i_flush      (w_flush),
        .i_valid      (w_valid),
        .i_pc         (r_pc),
        .i_inst       (r_buf),
        .o_pc         (id_pc),
        .o_inst       (id_inst)
    );

endmodule
`default_nettype wire
